// File: rtl/midi_msg_tx.sv
// midi_msg_tx: MIDI message serializer (8N1 UART) with running-status suppression
module midi_msg_tx #(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int BAUD_RATE      = 31250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic [1:0] msg_length,
    output logic       tx,
    output logic       busy,
    output logic       msg_error
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [1:0]    byte_num;
    logic [7:0]    byte0, byte1, byte2;
    logic [7:0]    last_status;
    logic          last_valid;
    logic          accept, bad, chan, skip, bit_end;
    logic [7:0]    cur_byte, data1_m, data2_m;

    assign accept   = msg_valid && msg_ready;
    assign bad      = !msg_status[7] || msg_length == 2'd0;
    // with bit 7 set, anything below 0xF0 is a channel message
    assign chan     = msg_status[7:4] != 4'hF;
    assign skip     = RUNNING_STATUS != 0 && chan && last_valid && msg_status == last_status && msg_length > 2'd1;
    assign data1_m  = msg_data1 & 8'h7F;
    assign data2_m  = msg_data2 & 8'h7F;
    assign bit_end  = bit_cnt == LAST_CNT;
    assign cur_byte = byte_idx == 2'd2 ? byte2 : byte_idx == 2'd1 ? byte1 : byte0;
    // a rejected message holds ready low for the single cycle its error pulse is visible
    assign msg_ready = state == IDLE && !msg_error;
    assign busy      = state != IDLE;
    assign tx        = state == START ? 1'b0 : state == DATA ? cur_byte[bit_idx] : 1'b1;

    // frame sequencer: loads the byte list on accept, then walks start/data/stop per byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            byte_num    <= '0;
            byte0       <= '0;
            byte1       <= '0;
            byte2       <= '0;
            last_status <= '0;
            last_valid  <= 1'b0;
            msg_error   <= 1'b0;
        end else begin
            msg_error <= accept && bad;
            bit_cnt   <= (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
            case (state)
                IDLE: if (accept && !bad) begin
                    state    <= START;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                    byte0    <= skip ? data1_m : msg_status;
                    byte1    <= skip ? data2_m : data1_m;
                    byte2    <= data2_m;
                    byte_num <= skip ? msg_length - 2'd1 : msg_length;
                    if (chan) begin
                        last_status <= msg_status;
                        last_valid  <= 1'b1;
                    end else if (!msg_status[3]) begin
                        last_valid  <= 1'b0;
                    end
                end
                START: if (bit_end) state <= DATA;
                DATA: if (bit_end) begin
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end
                STOP: if (bit_end) begin
                    if (byte_idx + 2'd1 < byte_num) begin
                        byte_idx <= byte_idx + 2'd1;
                        state    <= START;
                    end else begin
                        byte_idx <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_midi_msg_tx.sv
// tb_midi_msg_tx: directed bench with a bit-stream model, a UART receiver and literal byte checks
module tb_midi_msg_tx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       msg_valid = 1'b0;
    logic [7:0] msg_status = '0, msg_data1 = '0, msg_data2 = '0;
    logic [1:0] msg_length = '0;
    logic       msg_ready, tx, busy, msg_error;
    int checks = 0, errors = 0;
    bit cmp_en = 0;

    midi_msg_tx #(.CLOCK_FREQ(160), .BAUD_RATE(10), .RUNNING_STATUS(1)) dut (
        .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
        .msg_length(msg_length), .tx(tx), .busy(busy), .msg_error(msg_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: the expected tx line as a queue of per-cycle bits
    bit         wave[$];
    logic [7:0] m_last = '0;
    bit         m_last_v = 0;
    bit         m_tx = 1, m_busy = 0, m_ready = 1, m_err = 0, m_acc = 0;

    function automatic void push_byte(input logic [7:0] b);
        repeat (CPB) wave.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (CPB) wave.push_back(b[i]);
        repeat (CPB) wave.push_back(1'b1);
    endfunction

    function automatic void model_accept(input logic [7:0] st, d1, d2, input logic [1:0] len);
        bit is_chan, sup;
        if (st < 8'h80 || len == 0) begin
            m_err = 1;
            return;
        end
        is_chan = st <= 8'hEF;
        sup = is_chan && m_last_v && st == m_last && len > 1;
        if (!sup) push_byte(st);
        if (len >= 2) push_byte(d1 & 8'h7F);
        if (len == 3) push_byte(d2 & 8'h7F);
        if (is_chan) begin
            m_last = st;
            m_last_v = 1;
        end else if (st <= 8'hF7) m_last_v = 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wave.delete();
            m_last_v = 0;
            m_err = 0;
        end else begin
            m_acc = msg_valid && m_ready;
            if (wave.size() > 0) void'(wave.pop_front());
            m_err = 0;
            if (m_acc) model_accept(msg_status, msg_data1, msg_data2, msg_length);
        end
        m_tx    = wave.size() > 0 ? wave[0] : 1'b1;
        m_busy  = wave.size() > 0;
        m_ready = !m_busy && !m_err;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_tx", int'(tx), int'(m_tx));
            check("cyc_busy", int'(busy), int'(m_busy));
            check("cyc_ready", int'(msg_ready), int'(m_ready));
            check("cyc_error", int'(msg_error), int'(m_err));
        end
    end

    // independent UART receiver sampling mid-bit
    logic [7:0] rx_q[$];
    logic [7:0] r_byte = '0;
    int  r_cnt = 0;
    bit  r_act = 0;
    always @(negedge clk) begin
        if (reset) r_act = 0;
        else if (!r_act) begin
            if (tx === 1'b0) begin
                r_act = 1;
                r_cnt = 0;
            end
        end else begin
            r_cnt++;
            if (r_cnt == CPB / 2) check("rx_start_bit", int'(tx), 0);
            if (r_cnt % CPB == CPB / 2 && r_cnt / CPB >= 1 && r_cnt / CPB <= 8) r_byte[r_cnt / CPB - 1] = tx;
            if (r_cnt == 9 * CPB + CPB / 2) begin
                check("rx_stop_bit", int'(tx), 1);
                rx_q.push_back(r_byte);
                r_act = 0;
            end
        end
    end

    task automatic send(input logic [7:0] st, d1, d2, input logic [1:0] len,
                        input int n_exp, input logic [23:0] exp_bytes, input int exp_err);
        int t, bcnt, ecnt;
        logic [7:0] eb;
        rx_q.delete();
        @(posedge clk);
        #1;
        msg_status = st; msg_data1 = d1; msg_data2 = d2; msg_length = len; msg_valid = 1;
        t = 0;
        while (!msg_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        msg_valid = 0;
        msg_status = 8'($urandom()); msg_data1 = 8'($urandom()); msg_data2 = 8'($urandom());
        msg_length = 2'($urandom());
        bcnt = 0; ecnt = 0;
        for (t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (msg_error) ecnt++;
            if (n_exp > 0 && t == 0) msg_valid = 1;
            if (n_exp > 0 && t == 20) msg_valid = 0;
            if (!busy && msg_ready) break;
        end
        msg_valid = 0;
        if (t >= 4000) check("idle_timeout", 0, 1);
        check("busy_cycles", bcnt, n_exp * 10 * CPB);
        check("ready_return", t, exp_err != 0 ? 1 : n_exp * 10 * CPB);
        check("error_pulses", ecnt, exp_err);
        check("rx_count", rx_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < rx_q.size(); i++) begin
            eb = exp_bytes[23 - 8 * i -: 8];
            check("rx_byte", int'(rx_q[i]), int'(eb));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_ready", int'(msg_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(msg_error), 0);
        @(negedge clk);
        reset = 0;
        cmp_en = 1;
        send(8'h90, 8'h3C, 8'h64, 2'd3, 3, 24'h903C64, 0);
        send(8'h90, 8'h3C, 8'h00, 2'd3, 2, 24'h3C0000, 0);
        send(8'hF8, 8'h00, 8'h00, 2'd1, 1, 24'hF80000, 0);
        send(8'h90, 8'h3C, 8'h40, 2'd3, 2, 24'h3C4000, 0);
        send(8'hF2, 8'h00, 8'h00, 2'd1, 1, 24'hF20000, 0);
        send(8'h90, 8'h3C, 8'h40, 2'd3, 3, 24'h903C40, 0);
        send(8'h3C, 8'h3C, 8'h64, 2'd3, 0, 24'h000000, 1);
        send(8'h90, 8'h3C, 8'h64, 2'd0, 0, 24'h000000, 1);
        send(8'h90, 8'h3C, 8'h40, 2'd3, 2, 24'h3C4000, 0);
        send(8'h80, 8'hBC, 8'h11, 2'd3, 3, 24'h803C11, 0);
        send(8'h80, 8'h00, 8'h00, 2'd1, 1, 24'h800000, 0);
        send(8'hC0, 8'h05, 8'h00, 2'd2, 2, 24'hC00500, 0);
        send(8'hC0, 8'h06, 8'h00, 2'd2, 1, 24'h060000, 0);
        send(8'h90, 8'h3C, 8'h64, 2'd3, 3, 24'h903C64, 0);
        // abort mid second frame, then confirm the status byte is re-sent
        @(posedge clk);
        #1;
        msg_status = 8'h90; msg_data1 = 8'h3C; msg_data2 = 8'h64; msg_length = 2'd3; msg_valid = 1;
        @(posedge clk);
        #1;
        msg_valid = 0;
        repeat (10 * CPB + 50) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #2;
        reset = 1;
        #1;
        check("async_tx", int'(tx), 1);
        check("async_ready", int'(msg_ready), 1);
        check("async_busy", int'(busy), 0);
        check("async_error", int'(msg_error), 0);
        repeat (3) @(negedge clk);
        reset = 0;
        send(8'h90, 8'h3C, 8'h64, 2'd3, 3, 24'h903C64, 0);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
